// File: rtl/key_pkg.sv
// Shared key/action definitions: action codes, the ASCII-to-action map and the
// holdoff FSM state type used by key_event_queue and game-logic consumers.
package key_pkg;

    localparam int CODE_W_DEF = 4;

    localparam logic [2:0] KEY_NONE   = 3'd0;
    localparam logic [2:0] KEY_UP     = 3'd1;
    localparam logic [2:0] KEY_DOWN   = 3'd2;
    localparam logic [2:0] KEY_LEFT   = 3'd3;
    localparam logic [2:0] KEY_RIGHT  = 3'd4;
    localparam logic [2:0] KEY_SELECT = 3'd5;
    localparam logic [2:0] KEY_BACK   = 3'd6;

    typedef enum logic {
        HOLD_IDLE,
        HOLD_ACTIVE
    } holdoff_state_e;

    // Case-insensitive: lower/upper ASCII letters differ only in bit 5.
    function automatic logic [2:0] map_key(input logic [7:0] k);
        logic [2:0] code;
        code = KEY_NONE;
        case (k)
            8'h77, 8'h57: code = KEY_UP;
            8'h73, 8'h53: code = KEY_DOWN;
            8'h61, 8'h41: code = KEY_LEFT;
            8'h64, 8'h44: code = KEY_RIGHT;
            8'h20, 8'h7A, 8'h5A: code = KEY_SELECT;
            8'h78, 8'h58: code = KEY_BACK;
            default: code = KEY_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through event FIFO with occupancy count and a one-cycle
// overflow pulse when a push is dropped because the FIFO is full.
module event_fifo #(
    parameter int DEPTH  = 4,
    parameter int CODE_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [CODE_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [CODE_W-1:0]        data_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              do_push, do_pop, full;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i && valid_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = push_i && full && !do_pop;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o     = valid_o ? mem_q[rd_ptr_q] : '0;
    assign full_o     = full;
    assign overflow_o = overflow_q;
    assign count_o    = count_q;

endmodule

// File: rtl/key_event_queue.sv
// Maps received ASCII keys to action codes and queues them for the game logic.
// Optional duplicate suppression is built only when KEY_HOLDOFF_EN is defined.
module key_event_queue
    import key_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int CODE_W         = CODE_W_DEF,
    parameter int HOLDOFF_CYCLES = 5_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             key,
    input  logic                   key_valid,
    output logic [CODE_W-1:0]      ev_code,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic                   full,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count
);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("key_event_queue: DEPTH must be a power of 2 in 2..16");
    end
    if (CODE_W < 3 || HOLDOFF_CYCLES < 2) begin : g_bad_param
        $error("key_event_queue: CODE_W >= 3 and HOLDOFF_CYCLES >= 2 required");
    end

    logic [2:0]        code_raw;
    logic [CODE_W-1:0] code_ext;
    logic              key_hit;
    logic              push;

    assign code_raw = map_key(key);
    assign code_ext = CODE_W'(code_raw);
    assign key_hit  = key_valid && (code_raw != KEY_NONE);

`ifdef KEY_HOLDOFF_EN
    localparam int HCNT_W = $clog2(HOLDOFF_CYCLES);

    holdoff_state_e    state_q, state_d;
    logic [CODE_W-1:0] last_code_q, last_code_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              suppress;

    assign suppress = (state_q == HOLD_ACTIVE) && (code_ext == last_code_q);
    assign push     = key_hit && !suppress;

    always_comb begin
        state_d     = state_q;
        last_code_d = last_code_q;
        hcnt_d      = hcnt_q;
        case (state_q)
            HOLD_IDLE: ;
            HOLD_ACTIVE: begin
                if (hcnt_q == '0) state_d = HOLD_IDLE;
                else              hcnt_d  = hcnt_q - 1'b1;
            end
            default: state_d = HOLD_IDLE;
        endcase
        // Any accepted code opens a fresh window, even if the FIFO drops it.
        if (push) begin
            state_d     = HOLD_ACTIVE;
            last_code_d = code_ext;
            hcnt_d      = HCNT_W'(HOLDOFF_CYCLES - 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HOLD_IDLE;
            last_code_q <= '0;
            hcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            last_code_q <= last_code_d;
            hcnt_q      <= hcnt_d;
        end
    end
`else
    assign push = key_hit;
`endif

    event_fifo #(
        .DEPTH  (DEPTH),
        .CODE_W (CODE_W)
    ) u_fifo (
        .clk        (clk),
        .rst_i      (reset),
        .push_i     (push),
        .data_i     (code_ext),
        .pop_i      (ev_ready),
        .data_o     (ev_code),
        .valid_o    (ev_valid),
        .full_o     (full),
        .overflow_o (overflow),
        .count_o    (count)
    );

endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue: a key-map vector table plus
// hand-written FIFO, overflow, reset and (with KEY_HOLDOFF_EN) holdoff sequences.
module tb_key_event_queue;

`ifdef KEY_HOLDOFF_EN
    localparam int HO  = 10;
    localparam int GAP = 12;
`else
    localparam int HO  = 5_000_000;
    localparam int GAP = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] key;
    logic       key_valid;
    logic [3:0] ev_code;
    logic       ev_valid;
    logic       ev_ready;
    logic       full;
    logic       overflow;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] key;
        logic [3:0] exp_code;
    } vec_t;

    vec_t vecs [16];

    key_event_queue #(
        .DEPTH          (4),
        .CODE_W         (4),
        .HOLDOFF_CYCLES (HO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key       (key),
        .key_valid (key_valid),
        .ev_code   (ev_code),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .full      (full),
        .overflow  (overflow),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        for (int i = 0; i < GAP; i++) tick();
    endtask

    task automatic push_key(input logic [7:0] k);
        key       = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic pop_chk(input string name, input logic [3:0] exp);
        chk({name, "_valid"}, 32'(ev_valid), 32'd1);
        chk({name, "_code"}, 32'(ev_code), 32'(exp));
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{8'h77, 4'd1};  vecs[1]  = '{8'h73, 4'd2};
        vecs[2]  = '{8'h61, 4'd3};  vecs[3]  = '{8'h64, 4'd4};
        vecs[4]  = '{8'h20, 4'd5};  vecs[5]  = '{8'h78, 4'd6};
        vecs[6]  = '{8'h70, 4'd0};  vecs[7]  = '{8'h57, 4'd1};
        vecs[8]  = '{8'h53, 4'd2};  vecs[9]  = '{8'h01, 4'd0};
        vecs[10] = '{8'h41, 4'd3};  vecs[11] = '{8'h44, 4'd4};
        vecs[12] = '{8'h7A, 4'd5};  vecs[13] = '{8'h58, 4'd6};
        vecs[14] = '{8'h1F, 4'd0};  vecs[15] = '{8'h5A, 4'd5};

        reset = 1'b1; key = 8'h00; key_valid = 1'b0; ev_ready = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_code", 32'(ev_code), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Key map: one push (or discard) then pop per vector.
        for (int i = 0; i < 16; i++) begin
            push_key(vecs[i].key);
            if (vecs[i].exp_code != 4'd0) begin
                pop_chk($sformatf("map%0d", i), vecs[i].exp_code);
            end else begin
                chk($sformatf("map%0d_valid", i), 32'(ev_valid), 32'd0);
                tick();
            end
            chk($sformatf("map%0d_count", i), 32'(count), 32'd0);
            gap();
        end

        // Two strobes, valid one cycle after the first, FIFO order preserved.
        key = 8'h77; key_valid = 1'b1;
        chk("seq_pre_valid", 32'(ev_valid), 32'd0);
        tick();
        key = 8'h44;
        chk("seq_valid1", 32'(ev_valid), 32'd1);
        tick();
        key_valid = 1'b0;
        chk("seq_count2", 32'(count), 32'd2);
        pop_chk("seq_pop1", 4'd1);
        pop_chk("seq_pop2", 4'd4);
        chk("seq_empty", 32'(ev_valid), 32'd0);
        gap();

        // Fill to full, fifth push drops with a single overflow pulse.
        push_key(8'h77); push_key(8'h73); push_key(8'h61); push_key(8'h64);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_ovf0", 32'(overflow), 32'd0);
        push_key(8'h20);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        tick();
        chk("ovf_clear", 32'(overflow), 32'd0);
        pop_chk("ovf_pop1", 4'd1);
        pop_chk("ovf_pop2", 4'd2);
        pop_chk("ovf_pop3", 4'd3);
        pop_chk("ovf_pop4", 4'd4);
        chk("ovf_empty", 32'(count), 32'd0);
        gap();

        // Full with simultaneous push and pop.
        push_key(8'h77); push_key(8'h73); push_key(8'h61); push_key(8'h64);
        key = 8'h78; key_valid = 1'b1; ev_ready = 1'b1;
        tick();
        key_valid = 1'b0; ev_ready = 1'b0;
        chk("pp_count", 32'(count), 32'd4);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_full", 32'(full), 32'd1);
        pop_chk("pp_pop1", 4'd2);
        pop_chk("pp_pop2", 4'd3);
        pop_chk("pp_pop3", 4'd4);
        pop_chk("pp_pop4", 4'd6);
        gap();

        // Asynchronous reset mid-operation.
        push_key(8'h77); push_key(8'h73); push_key(8'h61);
        chk("ar_count3", 32'(count), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_valid", 32'(ev_valid), 32'd0);
        chk("ar_code", 32'(ev_code), 32'd0);
        chk("ar_full", 32'(full), 32'd0);
        key = 8'h77; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        reset = 1'b0;
        chk("ar_ignore", 32'(count), 32'd0);
        tick();
        push_key(8'h78);
        pop_chk("ar_post", 4'd6);
        gap();

`ifdef KEY_HOLDOFF_EN
        // 's' at t=0,5,12 and 'a' at t=6: only t=5 is suppressed.
        for (int t = 0; t <= 12; t++) begin
            key       = (t == 6) ? 8'h61 : 8'h73;
            key_valid = (t == 0 || t == 5 || t == 6 || t == 12);
            tick();
        end
        key_valid = 1'b0;
        chk("ho_count", 32'(count), 32'd3);
        pop_chk("ho_pop1", 4'd2);
        pop_chk("ho_pop2", 4'd3);
        pop_chk("ho_pop3", 4'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
